// File: rtl/buffer_pipeline.sv
// Pipeline register stage with valid/ready handshake, flush and bubble counter.
// Define BUFFER_PIPELINE_SKID_EN for a main+skid buffer with registered in_ready.
`timescale 1ns/1ps
module buffer_pipeline #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_DATA = 3,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_DATA*DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]         in_reg,
  input  logic                     in_zero,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_DATA*DATA_W-1:0] out_data,
  output logic [REG_W-1:0]         out_reg,
  output logic                     out_zero,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam int unsigned BUS_W = N_DATA * DATA_W;
  localparam int unsigned PAY_W = BUS_W + REG_W + 1 + CTRL_W;

  logic [PAY_W-1:0]  in_pay;
  logic [PAY_W-1:0]  main_pay;
  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic              accept;
  logic              retire;

  assign in_pay = {in_data, in_reg, in_zero, in_ctrl};
  assign accept = in_valid & in_ready & ~flush;
  assign retire = main_valid & out_ready;

  assign {out_data, out_reg, out_zero, main_ctrl} = main_pay;
  assign out_valid = main_valid;
  // Bubbles must never carry a write or branch enable downstream
  assign out_ctrl  = main_valid ? main_ctrl : '0;

`ifdef BUFFER_PIPELINE_SKID_EN
  logic             skid_valid;
  logic [PAY_W-1:0] skid_pay;

  assign in_ready = ~skid_valid;

  // Skid parks the input that arrives while main stalls; main refills from skid first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pay   <= '0;
      skid_pay   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (retire) begin
        main_pay   <= skid_pay;
        skid_valid <= 1'b0;
      end
    end else if (main_valid && !retire) begin
      if (accept) begin
        skid_pay   <= in_pay;
        skid_valid <= 1'b1;
      end
    end else if (accept) begin
      main_pay   <= in_pay;
      main_valid <= 1'b1;
    end else begin
      main_valid <= 1'b0;
    end
  end
`else
  assign in_ready = out_ready | ~main_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_pay   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (accept) begin
      main_pay   <= in_pay;
      main_valid <= 1'b1;
    end else if (retire) begin
      main_valid <= 1'b0;
    end
  end
`endif

  // Saturating count of edges that saw no valid output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (!main_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/buffer_pipeline.md
BUFFER_PIPELINE -- requirements
Module: buffer_pipeline

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each data word.
REQ-002 SHALL have parameter N_DATA, default 3, number of data words carried (branch target, ALU result, store data).
REQ-003 SHALL have parameter REG_W, default 5, destination register index width.
REQ-004 SHALL have parameter CTRL_W, default 5, control bit count (Branch, MemRead, MemWrite, RegWrite, MemToReg).
REQ-005 SHALL have parameter CNT_W, default 16, bubble counter width.
REQ-006 SHALL have ports: clk  in  1  clock, rising edge; rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports: in_valid  in  1  upstream holds a valid instruction; in_ready  out  1  stage accepts input this cycle.
REQ-008 SHALL have ports: in_data  in  N_DATA*DATA_W  packed data words, word 0 in LSBs; in_reg  in  REG_W  destination index; in_zero  in  1  ALU zero flag; in_ctrl  in  CTRL_W  control bits.
REQ-009 SHALL have ports: flush  in  1  kill all held and incoming instructions.
REQ-010 SHALL have ports: out_valid  out  1; out_ready  in  1  downstream accepts; out_data  out  N_DATA*DATA_W; out_reg  out  REG_W; out_zero  out  1; out_ctrl  out  CTRL_W.
REQ-011 SHALL have port: bubble_cnt  out  CNT_W  count of cycles with out_valid low since reset.

Function
REQ-012 SHALL accept an input on a rising edge iff in_valid and in_ready are high and flush is low.
REQ-013 SHALL retire the output on a rising edge iff out_valid and out_ready are high.
REQ-014 SHALL present an accepted instruction on out_* at the next edge: latency 1 cycle, throughput 1 per cycle when out_ready is held high.
REQ-015 SHALL hold out_data, out_reg, out_zero, out_ctrl and out_valid stable while out_valid is high and out_ready is low.
REQ-016 SHALL drive out_ctrl to all zeros whenever out_valid is low, so bubbles never assert a write or branch.
REQ-017 SHALL, on flush high at an edge, clear out_valid and every internal valid and discard in_data presented that cycle, regardless of out_ready.
REQ-018 SHALL keep data registers unchanged when no transfer occurs; only valid bits gate meaning.
REQ-019 SHALL preserve instruction order; no instruction duplicated or dropped except by flush.
REQ-020 SHALL increment bubble_cnt on each edge where out_valid is low and rst_n is high, saturating at all ones (no wrap).
REQ-021 SHALL, when in_valid and a retire occur in the same cycle, both accept and retire (pass-through, no bubble).

Reset
REQ-022 SHALL, on rst_n low at a rising edge: out_valid=0, internal valids=0, out_data=0, out_reg=0, out_zero=0, out_ctrl=0, bubble_cnt=0.
REQ-023 SHALL drive in_ready=1 in the first cycle after reset release.
REQ-024 SHALL give reset priority over flush and all transfers; reset mid-stall discards held instructions.

Configuration
REQ-025 SHALL use macro BUFFER_PIPELINE_SKID_EN to select the buffering structure.
REQ-026 SHALL, with BUFFER_PIPELINE_SKID_EN defined, contain main plus one skid entry; in_ready is a register output equal to NOT skid_valid, no combinational path from out_ready to in_ready.
REQ-027 SHALL, with skid, park an input accepted while the main entry stalls into the skid entry, and refill main from skid on the next retire before accepting new data into skid.
REQ-028 SHALL, without BUFFER_PIPELINE_SKID_EN, contain one entry with in_ready = out_ready OR NOT out_valid (combinational).
REQ-029 SHALL keep identical port list, latency and ordering in both builds.

Verification
REQ-030 SHALL cover: reset, then in_valid=1, in_data word1=32'h0000_0010, in_ctrl=5'b01010, out_ready=1 -> next cycle out_valid=1, word1=32'h10, out_ctrl=5'b01010.
REQ-031 SHALL cover: stream 8 items with out_ready=1 -> 8 consecutive out_valid cycles, in order, bubble_cnt unchanged.
REQ-032 SHALL cover (skid build): out_ready=0 for 3 cycles while in_valid=1 -> 2 items held, in_ready=0 from 2nd edge, out_* stable; out_ready=1 -> both emerge in order.
REQ-033 SHALL cover: flush=1 with 2 items held and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, flushed items never appear.
REQ-034 SHALL cover: CNT_W=4, idle 20 cycles -> bubble_cnt saturates at 4'hF; rst_n=0 one cycle -> bubble_cnt=0, out_valid=0.
